ram_init_ctrl: RTL and testbench
================================

Name: ram_init_ctrl

Overview:
- AXI4 master that sequences initialisation of the on-chip AXI RAM after reset: fills every location with a pattern in INCR bursts, then optionally reads everything back and compares.
- Drives the RAM init_done/init_error status consumed by veerwolf_core (i_ram_init_done, i_ram_init_error).
- Sits between the clk_gen reset domain and the RAM slave port. The RAM port is muxed to the core only after o_init_done.

Parameters:
- ADDR_WIDTH, 16, RAM byte-address width; RAM size is 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 64, AXI data width; must be 32 or 64.
- ID_WIDTH, 6, AXI ID width; all IDs are driven 0.
- BURST_LEN, 16, beats per burst; power of 2, 1..256; BURST_LEN*DATA_WIDTH/8 divides 2**ADDR_WIDTH.
- FILL_PATTERN, 64'h0, fill value; the low DATA_WIDTH bits are used.
- CHECK, 1, 1 = read-back verify phase, 0 = fill only.
- AUTO_START, 1, 1 = begin the first cycle after rst deasserts.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- i_start  in  1  start pulse; honoured in IDLE/DONE/ERROR
- o_busy  out  1  high while sequencing
- o_init_done  out  1  sticky; sequence passed
- o_init_error  out  1  sticky; sequence failed
- o_err_addr  out  ADDR_WIDTH  byte address of the first failing beat
- o_awid/o_awaddr/o_awlen/o_awsize/o_awburst/o_awvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1  AW channel
- i_awready  in  1
- o_wdata/o_wstrb/o_wlast/o_wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel
- i_wready  in  1
- i_bid/i_bresp/i_bvalid  in  ID_WIDTH/2/1;  o_bready  out  1
- o_arid/o_araddr/o_arlen/o_arsize/o_arburst/o_arvalid  out  as AW;  i_arready  in  1
- i_rid/i_rdata/i_rresp/i_rlast/i_rvalid  in  ID_WIDTH/DATA_WIDTH/2/1/1;  o_rready  out  1

Behaviour:
- Reset: all valid/ready outputs 0, o_busy/o_init_done/o_init_error 0, o_err_addr 0, state IDLE. Reset mid-operation aborts at once; the RAM shares rst.
- Static outputs:
  - len = BURST_LEN-1
  - size = log2(DATA_WIDTH/8)
  - burst = 2'b01 (INCR)
  - wstrb all ones
  - wdata = FILL_PATTERN
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE, ERROR.
- IDLE -> WADDR on i_start, or the first post-reset cycle when AUTO_START=1. Entering WADDR clears done/error/err_addr, zeroes the burst address, and sets o_busy.
- WADDR: o_awvalid=1 with awaddr stable until i_awready, then -> WDATA.
- WDATA:
  - o_wvalid=1; the beat counter advances on i_wready.
  - o_wlast=1 on beat BURST_LEN-1; accept of that beat -> WRESP.
  - wvalid never drops while un-accepted.
- WRESP: o_bready=1. On i_bvalid:
  - bresp!=0 -> ERROR, with err_addr = burst address.
  - else if burst is last -> RADDR (CHECK=1, address reset to 0) or DONE (CHECK=0).
  - else address += BURST_LEN*DATA_WIDTH/8 -> WADDR.
- Single outstanding transaction only; AW and W never overlap.
- RADDR: o_arvalid=1 until i_arready -> RDATA.
- RDATA: o_rready=1. Each beat is an error if any of these hold:
  - rdata != pattern
  - rresp != 0
  - rlast != (beat==BURST_LEN-1)
- On the first error in a burst, latch err_addr = burst address + beat*DATA_WIDTH/8 (first error only). Keep rready high and drain to the rlast beat, then -> ERROR.
- RDATA exit with no error: more bursts -> RADDR with address incremented; last burst -> DONE.
- DONE: o_init_done=1, o_busy=0. ERROR: o_init_error=1, o_busy=0. Both hold until rst or i_start; i_start restarts at WADDR.
- i_start while o_busy is ignored.
- Address counter is ADDR_WIDTH bits. The last burst is detected by comparison, so no wrap occurs.
- Beat counter is 8 bits, compared against BURST_LEN-1.

Test Plan:
- ADDR_WIDTH=8, DATA_WIDTH=64, BURST_LEN=16, CHECK=1, zero-wait slave -> 2 write bursts (awaddr 0x00, 0x80), 2 read bursts; o_init_done rises, o_busy falls the same cycle, RAM all 0.
- Same config, slave stalls awready 3 cycles and randomly toggles wready/rvalid -> awaddr/wdata stay stable while valid; exactly 32 W beats; wlast only on beats 15 and 31; done=1.
- Slave returns rdata mismatch on beat 5 of burst 1 -> o_err_addr=0x80+5*8=0xA8; rready held until rlast; then o_init_error=1, done=0.
- bresp=2'b10 on the first burst -> ERROR with err_addr=0x00; no AR issued.
- CHECK=0, AUTO_START=0: no activity until i_start; after i_start, 2 write bursts then done with no AR. A second i_start in DONE clears done and reruns.
- rst asserted mid-WDATA -> next cycle all valids 0, busy 0; with AUTO_START=1, the sequence restarts from awaddr 0 after rst falls.

Source files
------------

// File: rtl/ram_init_ctrl.sv
// AXI4 master that fills the on-chip RAM with a constant pattern after reset and optionally
// reads it back to verify; reports sticky done/error status and the first failing address.
module ram_init_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ID_WIDTH     = 6,
  parameter int unsigned BURST_LEN    = 16,
  parameter logic [63:0] FILL_PATTERN = 64'h0,
  parameter bit          CHECK        = 1'b1,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_init_done,
  output logic                    o_init_error,
  output logic [ADDR_WIDTH-1:0]   o_err_addr,
  output logic [ID_WIDTH-1:0]     o_awid,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic [7:0]              o_awlen,
  output logic [2:0]              o_awsize,
  output logic [1:0]              o_awburst,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  output logic                    o_wlast,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  input  logic [ID_WIDTH-1:0]     i_bid,
  input  logic [1:0]              i_bresp,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  output logic [ID_WIDTH-1:0]     o_arid,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  input  logic [ID_WIDTH-1:0]     i_rid,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rlast,
  input  logic                    i_rvalid,
  output logic                    o_rready
);

  localparam int unsigned           Bytes    = DATA_WIDTH / 8;
  localparam logic [2:0]            AxSize   = 3'($clog2(Bytes));
  localparam logic [7:0]            BeatLast = 8'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(BURST_LEN * Bytes);
  // Base of the final burst; modular negate also covers a single burst spanning the RAM.
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ~AddrStep + ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] Pattern  = FILL_PATTERN[DATA_WIDTH-1:0];

  typedef enum logic [2:0] {
    StIdle, StWaddr, StWdata, StWresp, StRaddr, StRdata, StDone, StError
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            beat_q, beat_d;
  logic                  rerr_q, rerr_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  busy_q, busy_d;
  logic                  auto_q, auto_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  wlast_q, wlast_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  start_seq;
  logic                  last_burst;
  logic                  beat_bad;

  assign last_burst = (addr_q == LastAddr);
  assign beat_bad   = (i_rdata != Pattern) || (i_rresp != 2'b00) ||
                      (i_rlast != (beat_q == BeatLast));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    rerr_d     = rerr_q;
    done_d     = done_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    busy_d     = busy_q;
    auto_d     = 1'b0;
    start_seq  = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_start || (AUTO_START && auto_q)) start_seq = 1'b1;
      end
      StWaddr: begin
        if (awvalid_q && i_awready) begin
          state_d = StWdata;
          beat_d  = '0;
        end
      end
      StWdata: begin
        if (wvalid_q && i_wready) begin
          beat_d = beat_q + 8'd1;
          if (beat_q == BeatLast) state_d = StWresp;
        end
      end
      StWresp: begin
        if (bready_q && i_bvalid) begin
          if (i_bresp != 2'b00) begin
            state_d    = StError;
            error_d    = 1'b1;
            err_addr_d = addr_q;
            busy_d     = 1'b0;
          end else if (last_burst) begin
            if (CHECK) begin
              state_d = StRaddr;
              addr_d  = '0;
            end else begin
              state_d = StDone;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            state_d = StWaddr;
            addr_d  = addr_q + AddrStep;
          end
        end
      end
      StRaddr: begin
        if (arvalid_q && i_arready) begin
          state_d = StRdata;
          beat_d  = '0;
          rerr_d  = 1'b0;
        end
      end
      StRdata: begin
        if (rready_q && i_rvalid) begin
          beat_d = beat_q + 8'd1;
          // Only the first bad beat of the burst is reported; the rest is drained.
          if (beat_bad && !rerr_q) begin
            rerr_d     = 1'b1;
            err_addr_d = addr_q + (ADDR_WIDTH'(beat_q) << AxSize);
          end
          if (i_rlast) begin
            if (rerr_q || beat_bad) begin
              state_d = StError;
              error_d = 1'b1;
              busy_d  = 1'b0;
            end else if (last_burst) begin
              state_d = StDone;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = StRaddr;
              addr_d  = addr_q + AddrStep;
            end
          end
        end
      end
      StDone, StError: begin
        if (i_start) start_seq = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (start_seq) begin
      state_d    = StWaddr;
      addr_d     = '0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_addr_d = '0;
      busy_d     = 1'b1;
    end

    // Handshake outputs are registered, so derive them from the next state.
    awvalid_d = (state_d == StWaddr);
    wvalid_d  = (state_d == StWdata);
    wlast_d   = (state_d == StWdata) && (beat_d == BeatLast);
    bready_d  = (state_d == StWresp);
    arvalid_d = (state_d == StRaddr);
    rready_d  = (state_d == StRdata);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      beat_q     <= '0;
      rerr_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      busy_q     <= 1'b0;
      auto_q     <= 1'b1;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      rerr_q     <= rerr_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      busy_q     <= busy_d;
      auto_q     <= auto_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      wlast_q    <= wlast_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_init_done  = done_q;
  assign o_init_error = error_q;
  assign o_err_addr   = err_addr_q;

  assign o_awid    = '0;
  assign o_awaddr  = addr_q;
  assign o_awlen   = BeatLast;
  assign o_awsize  = AxSize;
  assign o_awburst = 2'b01;
  assign o_awvalid = awvalid_q;

  assign o_wdata  = Pattern;
  assign o_wstrb  = '1;
  assign o_wlast  = wlast_q;
  assign o_wvalid = wvalid_q;
  assign o_bready = bready_q;

  assign o_arid    = '0;
  assign o_araddr  = addr_q;
  assign o_arlen   = BeatLast;
  assign o_arsize  = AxSize;
  assign o_arburst = 2'b01;
  assign o_arvalid = arvalid_q;
  assign o_rready  = rready_q;

  // Response IDs are irrelevant with a single outstanding transaction.
  logic unused_ids;
  assign unused_ids = ^{i_bid, i_rid};

endmodule

// File: tb/tb_ram_init_ctrl.sv
// Scoreboard bench: two controllers (verify+autostart, fill-only+manual start) against AXI slave
// models; expected AXI addresses, W beats and final status are queued and checked by monitors.
module tb_ram_init_ctrl;

  localparam logic [63:0] APAT = 64'h0;
  localparam logic [63:0] BPAT = 64'hA5A5_0F0F_1234_5678;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  logic a_start = 1'b0;
  logic b_start = 1'b0;
  logic [5:0] zero_id = '0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // ---------------- DUT A: CHECK=1, AUTO_START=1 ----------------
  logic [5:0]  a_awid, a_arid;
  logic [7:0]  a_awaddr, a_awlen, a_araddr, a_arlen, a_err_addr, a_wstrb;
  logic [2:0]  a_awsize, a_arsize;
  logic [1:0]  a_awburst, a_arburst, a_bresp, a_rresp;
  logic [63:0] a_wdata, a_rdata;
  logic a_awvalid, a_awready, a_wlast, a_wvalid, a_wready, a_bvalid, a_bready;
  logic a_arvalid, a_arready, a_rlast, a_rvalid, a_rready, a_busy, a_done, a_err;

  ram_init_ctrl #(
    .ADDR_WIDTH(8), .DATA_WIDTH(64), .ID_WIDTH(6), .BURST_LEN(16),
    .FILL_PATTERN(APAT), .CHECK(1'b1), .AUTO_START(1'b1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .i_start(a_start), .o_busy(a_busy), .o_init_done(a_done),
    .o_init_error(a_err), .o_err_addr(a_err_addr),
    .o_awid(a_awid), .o_awaddr(a_awaddr), .o_awlen(a_awlen), .o_awsize(a_awsize),
    .o_awburst(a_awburst), .o_awvalid(a_awvalid), .i_awready(a_awready),
    .o_wdata(a_wdata), .o_wstrb(a_wstrb), .o_wlast(a_wlast), .o_wvalid(a_wvalid),
    .i_wready(a_wready), .i_bid(zero_id), .i_bresp(a_bresp), .i_bvalid(a_bvalid),
    .o_bready(a_bready), .o_arid(a_arid), .o_araddr(a_araddr), .o_arlen(a_arlen),
    .o_arsize(a_arsize), .o_arburst(a_arburst), .o_arvalid(a_arvalid),
    .i_arready(a_arready), .i_rid(zero_id), .i_rdata(a_rdata), .i_rresp(a_rresp),
    .i_rlast(a_rlast), .i_rvalid(a_rvalid), .o_rready(a_rready)
  );

  // Slave A knobs and model (256-byte RAM, 32 x 64-bit words)
  int aw_stall = 0;
  int rnd = 0;
  int bad_b = -1;
  int bad_rb = -1;
  int bad_rbeat = -1;
  logic [63:0] mem [32];
  logic [4:0] wr_ptr, rd_ptr;
  int aw_wait, wburst, rd_beat, rd_burst, rburst_cnt;
  logic rd_active;

  always @(posedge clk) begin
    if (rst) begin
      a_awready <= 1'b0; aw_wait <= 0; a_wready <= 1'b0; a_bvalid <= 1'b0; a_bresp <= 2'b00;
      wr_ptr <= '0; wburst <= 0; a_arready <= 1'b0; a_rvalid <= 1'b0; a_rdata <= '0;
      a_rresp <= 2'b00; a_rlast <= 1'b0; rd_active <= 1'b0; rd_beat <= 0; rd_ptr <= '0;
      rd_burst <= 0; rburst_cnt <= 0;
      for (int i = 0; i < 32; i++) mem[i] <= 64'hDEAD_0000_0000_0000 | 64'(i);
    end else begin
      if (a_awvalid && a_awready) begin
        wr_ptr <= a_awaddr[7:3];
        aw_wait <= 0;
        a_awready <= (aw_stall == 0);
      end else if (a_awvalid) begin
        if (aw_wait >= aw_stall) a_awready <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end else begin
        a_awready <= (aw_stall == 0);
      end
      a_wready <= (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (a_wvalid && a_wready) begin
        mem[wr_ptr] <= a_wdata;
        wr_ptr <= wr_ptr + 5'd1;
        if (a_wlast) begin
          a_bvalid <= 1'b1;
          a_bresp <= (wburst == bad_b) ? 2'b10 : 2'b00;
          wburst <= wburst + 1;
        end
      end
      if (a_bvalid && a_bready) a_bvalid <= 1'b0;
      a_arready <= 1'b1;
      if (a_arvalid && a_arready) begin
        rd_active <= 1'b1; rd_ptr <= a_araddr[7:3]; rd_beat <= 0;
        rd_burst <= rburst_cnt; rburst_cnt <= rburst_cnt + 1;
      end
      if (rd_active && rd_beat < 16 && (!a_rvalid || a_rready) &&
          (rnd == 0 || $urandom_range(0, 1) == 1)) begin
        a_rvalid <= 1'b1;
        a_rdata <= mem[rd_ptr] ^ ((rd_burst == bad_rb && rd_beat == bad_rbeat) ? 64'h1 : 64'h0);
        a_rlast <= (rd_beat == 15);
        rd_beat <= rd_beat + 1;
        rd_ptr <= rd_ptr + 5'd1;
      end else if (a_rvalid && a_rready) begin
        a_rvalid <= 1'b0;
        if (a_rlast) rd_active <= 1'b0;
      end
    end
  end

  // Scoreboard A
  logic [7:0] qa_aw[$];
  logic [7:0] qa_ar[$];
  logic       qa_w[$];
  logic [9:0] qa_st[$];
  logic pa_aw_v, pa_aw_hs, pa_w_v, pa_w_hs, pa_busy;
  logic [7:0] pa_awaddr;

  always @(negedge clk) begin
    if (rst) begin
      pa_aw_v <= 1'b0; pa_aw_hs <= 1'b0; pa_w_v <= 1'b0; pa_w_hs <= 1'b0; pa_busy <= 1'b0;
      pa_awaddr <= '0;
    end else begin
      if (pa_aw_v && !pa_aw_hs) check("a_aw_hold", {a_awvalid, a_awaddr}, {1'b1, pa_awaddr});
      if (pa_w_v && !pa_w_hs) check("a_wvalid_hold", a_wvalid, 1);
      if (a_awvalid && a_awready) begin
        if (qa_aw.size() == 0) fail("a_aw_unexpected");
        else check("a_awaddr", a_awaddr, qa_aw.pop_front());
      end
      if (a_wvalid && a_wready) begin
        check("a_wdata", a_wdata, APAT);
        if (qa_w.size() == 0) fail("a_w_unexpected");
        else check("a_wlast", a_wlast, qa_w.pop_front());
      end
      if (a_arvalid && a_arready) begin
        if (qa_ar.size() == 0) fail("a_ar_unexpected");
        else check("a_araddr", a_araddr, qa_ar.pop_front());
      end
      if (a_rvalid) check("a_rready_held", a_rready, 1);
      if (pa_busy && !a_busy) begin
        if (qa_st.size() == 0) fail("a_status_unexpected");
        else check("a_status{done,err,addr}", {a_done, a_err, a_err_addr}, qa_st.pop_front());
      end
      pa_aw_v <= a_awvalid; pa_aw_hs <= a_awvalid && a_awready; pa_awaddr <= a_awaddr;
      pa_w_v <= a_wvalid; pa_w_hs <= a_wvalid && a_wready; pa_busy <= a_busy;
    end
  end

  task automatic clear_a();
    qa_aw.delete(); qa_ar.delete(); qa_w.delete(); qa_st.delete();
  endtask

  task automatic push_a(input int n_aw, input int n_ar, input logic done, input logic err,
                        input logic [7:0] ea);
    for (int i = 0; i < n_aw; i++) begin
      qa_aw.push_back(8'(i * 128));
      for (int j = 0; j < 16; j++) qa_w.push_back(j == 15);
    end
    for (int i = 0; i < n_ar; i++) qa_ar.push_back(8'(i * 128));
    qa_st.push_back({done, err, ea});
  endtask

  task automatic wait_a(input string name);
    int n = 0;
    while (qa_st.size() != 0 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (qa_st.size() != 0) fail(name);
    check({name, "_aw_left"}, qa_aw.size(), 0);
    check({name, "_w_left"}, qa_w.size(), 0);
    check({name, "_ar_left"}, qa_ar.size(), 0);
  endtask

  task automatic reset_a_begin();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_a();
    @(posedge clk); #1;
  endtask

  task automatic reset_a_end();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- DUT B: CHECK=0, AUTO_START=0 ----------------
  logic [5:0]  b_awid, b_arid;
  logic [7:0]  b_awaddr, b_awlen, b_araddr, b_arlen, b_err_addr, b_wstrb;
  logic [2:0]  b_awsize, b_arsize;
  logic [1:0]  b_awburst, b_arburst;
  logic [63:0] b_wdata;
  logic b_awvalid, b_wlast, b_wvalid, b_bvalid, b_bready, b_arvalid, b_rready;
  logic b_busy, b_done, b_err;
  logic b_awready, b_wready, b_arready;
  logic [1:0] b_resp0;
  logic [63:0] b_rdata0;
  logic b_zero;
  assign b_awready = 1'b1;
  assign b_wready  = 1'b1;
  assign b_arready = 1'b1;
  assign b_resp0   = 2'b00;
  assign b_rdata0  = '0;
  assign b_zero    = 1'b0;

  ram_init_ctrl #(
    .ADDR_WIDTH(8), .DATA_WIDTH(64), .ID_WIDTH(6), .BURST_LEN(16),
    .FILL_PATTERN(BPAT), .CHECK(1'b0), .AUTO_START(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .i_start(b_start), .o_busy(b_busy), .o_init_done(b_done),
    .o_init_error(b_err), .o_err_addr(b_err_addr),
    .o_awid(b_awid), .o_awaddr(b_awaddr), .o_awlen(b_awlen), .o_awsize(b_awsize),
    .o_awburst(b_awburst), .o_awvalid(b_awvalid), .i_awready(b_awready),
    .o_wdata(b_wdata), .o_wstrb(b_wstrb), .o_wlast(b_wlast), .o_wvalid(b_wvalid),
    .i_wready(b_wready), .i_bid(zero_id), .i_bresp(b_resp0), .i_bvalid(b_bvalid),
    .o_bready(b_bready), .o_arid(b_arid), .o_araddr(b_araddr), .o_arlen(b_arlen),
    .o_arsize(b_arsize), .o_arburst(b_arburst), .o_arvalid(b_arvalid),
    .i_arready(b_arready), .i_rid(zero_id), .i_rdata(b_rdata0), .i_rresp(b_resp0),
    .i_rlast(b_zero), .i_rvalid(b_zero), .o_rready(b_rready)
  );

  always @(posedge clk) begin
    if (rst_b) b_bvalid <= 1'b0;
    else if (b_wvalid && b_wlast) b_bvalid <= 1'b1;
    else if (b_bvalid && b_bready) b_bvalid <= 1'b0;
  end

  logic [7:0] qb_aw[$];
  logic [9:0] qb_st[$];
  int b_aw_cnt = 0;
  int b_w_cnt = 0;
  int b_ar_cnt = 0;
  logic pb_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst_b) begin
      if (b_awvalid && b_awready) begin
        b_aw_cnt <= b_aw_cnt + 1;
        if (qb_aw.size() == 0) fail("b_aw_unexpected");
        else check("b_awaddr", b_awaddr, qb_aw.pop_front());
      end
      if (b_wvalid && b_wready) begin
        check("b_wdata", b_wdata, BPAT);
        check("b_wlast", b_wlast, (b_w_cnt % 16) == 15);
        b_w_cnt <= b_w_cnt + 1;
      end
      if (b_arvalid || b_rready) b_ar_cnt <= b_ar_cnt + 1;
      if (pb_busy && !b_busy) begin
        if (qb_st.size() == 0) fail("b_status_unexpected");
        else check("b_status{done,err,addr}", {b_done, b_err, b_err_addr}, qb_st.pop_front());
      end
      pb_busy <= b_busy;
    end
  end

  task automatic pulse_start_b();
    @(posedge clk); #1; b_start = 1'b1;
    @(posedge clk); #1; b_start = 1'b0;
  endtask

  task automatic wait_b(input string name);
    int n = 0;
    while (qb_st.size() != 0 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (qb_st.size() != 0) fail(name);
    check({name, "_aw_left"}, qb_aw.size(), 0);
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    logic [63:0] mem_or;
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    check("a_reset_valids", {a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready}, 0);
    check("a_reset_status", {a_busy, a_done, a_err}, 0);
    check("a_reset_err_addr", a_err_addr, 0);

    // T1: zero-wait fill and verify
    push_a(2, 2, 1'b1, 1'b0, 8'h00);
    reset_a_end();
    wait_a("t1");
    mem_or = '0;
    for (int i = 0; i < 32; i++) mem_or = mem_or | mem[i];
    check("t1_ram_zero", mem_or, 0);
    check("a_static_ax", {a_awlen, a_awsize, a_awburst, a_arlen, a_arsize, a_arburst},
          {8'd15, 3'd3, 2'b01, 8'd15, 3'd3, 2'b01});
    check("a_static_w", {a_awid, a_arid, a_wstrb}, {6'd0, 6'd0, 8'hFF});
    check("t1_busy_done", {a_busy, a_done, a_err}, 3'b010);

    // T2: restart from DONE with AW stall and random W/R backpressure
    aw_stall = 3; rnd = 1;
    push_a(2, 2, 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1; a_start = 1'b1;
    @(posedge clk); #1; a_start = 1'b0;
    check("t2_start_clears_done", {a_busy, a_done}, 2'b10);
    wait_a("t2");
    aw_stall = 0; rnd = 0;

    // T3: corrupted read beat 5 of burst 1
    reset_a_begin();
    bad_rb = 1; bad_rbeat = 5;
    push_a(2, 2, 1'b0, 1'b1, 8'hA8);
    reset_a_end();
    wait_a("t3");
    bad_rb = -1; bad_rbeat = -1;

    // T4: write error response on the first burst, no reads follow
    reset_a_begin();
    bad_b = 0;
    push_a(1, 0, 1'b0, 1'b1, 8'h00);
    reset_a_end();
    wait_a("t4");
    repeat (5) @(posedge clk);
    #1;
    check("t4_error_sticky", {a_busy, a_done, a_err, a_arvalid}, 4'b0010);
    bad_b = -1;

    // T5: reset while writing, then auto restart from address 0
    reset_a_begin();
    push_a(2, 2, 1'b1, 1'b0, 8'h00);
    reset_a_end();
    n = 0;
    while (!a_wvalid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!a_wvalid) fail("t5_wdata_reached");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_a();
    @(posedge clk); #1;
    check("t5_abort_valids", {a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready}, 0);
    check("t5_abort_status", {a_busy, a_done, a_err}, 0);
    push_a(2, 2, 1'b1, 1'b0, 8'h00);
    reset_a_end();
    wait_a("t5");

    // DUT B: fill only, manual start
    check("b_idle_activity", {b_busy, b_done, b_err, b_awvalid, b_wvalid}, 0);
    check("b_idle_counts", {8'(b_aw_cnt), 8'(b_w_cnt)}, 0);
    qb_aw.push_back(8'h00); qb_aw.push_back(8'h80);
    qb_st.push_back({1'b1, 1'b0, 8'h00});
    pulse_start_b();
    wait_b("b1");
    check("b1_w_beats", b_w_cnt, 32);
    qb_aw.push_back(8'h00); qb_aw.push_back(8'h80);
    qb_st.push_back({1'b1, 1'b0, 8'h00});
    pulse_start_b();
    check("b2_start_clears_done", {b_busy, b_done}, 2'b10);
    wait_b("b2");
    check("b2_w_beats", b_w_cnt, 64);
    check("b_no_reads", b_ar_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
